// File: rtl/tbcm_packet_mux_pkg.sv
// Shared types and helpers for the packet mux: FSM state encoding and
// indexing into the packed upper-triangle LRG priority matrix.
package tbcm_packet_mux_pkg;

  typedef enum logic [0:0] {
    TBCM_PACKET_MUX_IDLE   = 1'b0,
    TBCM_PACKET_MUX_LOCKED = 1'b1
  } state_t;

  // Bit position of pair (row, col), row < col, in an n-requester triangle.
  function automatic int tri_idx(input int row, input int col, input int n);
    return row * n - (row * (row + 1)) / 2 + (col - row - 1);
  endfunction

endpackage

// File: rtl/tbcm_packet_mux_if.sv
// Requester-side and shared-channel signals of the packet mux.
// The mux itself uses the slave modport; the environment drives through master.
interface tbcm_packet_mux_if #(
  parameter int REQUESTS   = 2,
  parameter int DATA_WIDTH = 32
);

  logic [REQUESTS-1:0]                 i_valid;
  logic [REQUESTS-1:0]                 o_ready;
  logic [REQUESTS-1:0][DATA_WIDTH-1:0] i_data;
  logic [REQUESTS-1:0]                 i_last;
  logic                                o_valid;
  logic                                i_ready;
  logic [DATA_WIDTH-1:0]               o_data;
  logic                                o_last;
  logic [REQUESTS-1:0]                 o_grant;

  modport master (
    output i_valid, i_data, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_grant
  );

  modport slave (
    input  i_valid, i_data, i_last, i_ready,
    output o_ready, o_valid, o_data, o_last, o_grant
  );

endinterface

// File: rtl/tbcm_packet_mux_arbiter.sv
// Least-recently-granted arbiter. prio_q holds one bit per requester pair
// (row < col): 1 means the lower index currently wins over the higher one.
module tbcm_packet_mux_arbiter
  import tbcm_packet_mux_pkg::*;
#(
  parameter int REQUESTS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REQUESTS-1:0] request,
  input  logic                update,
  output logic [REQUESTS-1:0] grant
);

  localparam int PAIRS = REQUESTS * (REQUESTS - 1) / 2;

  logic [PAIRS-1:0] prio_q;

  function automatic logic wins(input logic [PAIRS-1:0] prio, input int a, input int b);
    if (a < b) return prio[tri_idx(a, b, REQUESTS)];
    return !prio[tri_idx(b, a, REQUESTS)];
  endfunction

  always_comb begin
    grant = '0;
    for (int i = 0; i < REQUESTS; i++) begin
      grant[i] = request[i];
      for (int j = 0; j < REQUESTS; j++) begin
        if (j != i && request[j] && wins(prio_q, j, i)) grant[i] = 1'b0;
      end
    end
  end

  // The granted requester drops below every other; untouched pairs keep their order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= '1;
    end else if (update) begin
      for (int i = 0; i < REQUESTS; i++) begin
        for (int j = i + 1; j < REQUESTS; j++) begin
          if (grant[i])      prio_q[tri_idx(i, j, REQUESTS)] <= 1'b0;
          else if (grant[j]) prio_q[tri_idx(i, j, REQUESTS)] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tbcm_packet_mux.sv
// Packet-atomic N:1 mux with LRG arbitration between packets.
//   state  | meaning
//   IDLE   | no owner; arbiter picks one combinationally from i_valid
//   LOCKED | owner held in grant_q until its last beat handshakes
module tbcm_packet_mux
  import tbcm_packet_mux_pkg::*;
#(
  parameter int REQUESTS   = 2,
  parameter int DATA_WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  tbcm_packet_mux_if.slave bus
);

  state_t                state_q;
  logic [REQUESTS-1:0]   grant_q;
  logic [REQUESTS-1:0]   arb_request;
  logic [REQUESTS-1:0]   arb_grant;
  logic [REQUESTS-1:0]   owner;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  handshake;
  logic                  last_handshake;

  // While LOCKED the arbiter sees only the held owner, so its grant is the owner in both states.
  assign arb_request = (state_q == TBCM_PACKET_MUX_LOCKED) ? grant_q : bus.i_valid;
  assign owner       = rst_n ? arb_grant : '0;

  tbcm_packet_mux_arbiter #(
    .REQUESTS (REQUESTS)
  ) u_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .request (arb_request),
    .update  (last_handshake),
    .grant   (arb_grant)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < REQUESTS; i++) begin
      if (owner[i]) begin
        sel_valid = sel_valid | bus.i_valid[i];
        sel_last  = sel_last  | bus.i_last[i];
        sel_data  = sel_data  | bus.i_data[i];
      end
    end
  end

  assign handshake      = sel_valid & bus.i_ready;
  assign last_handshake = handshake & sel_last;

  assign bus.o_valid = sel_valid;
  assign bus.o_last  = sel_last;
  assign bus.o_data  = sel_data;
  assign bus.o_grant = owner;
  assign bus.o_ready = owner & {REQUESTS{bus.i_ready}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TBCM_PACKET_MUX_IDLE;
      grant_q <= '0;
    end else begin
      case (state_q)
        TBCM_PACKET_MUX_IDLE: begin
          if (|owner && !last_handshake) begin
            state_q <= TBCM_PACKET_MUX_LOCKED;
            grant_q <= owner;
          end
        end
        TBCM_PACKET_MUX_LOCKED: begin
          if (last_handshake) begin
            state_q <= TBCM_PACKET_MUX_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= TBCM_PACKET_MUX_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbcm_packet_mux.sv
// Directed and randomized checks of tbcm_packet_mux (4 requesters, 32-bit)
// against a priority-list reference model.
module tb_tbcm_packet_mux;
  import tbcm_packet_mux_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tbcm_packet_mux_if #(.REQUESTS(N), .DATA_WIDTH(W)) bus ();

  tbcm_packet_mux #(.REQUESTS(N), .DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [N-1:0]        v, l;
  logic [N-1:0][W-1:0] d;
  logic                r;

  // Reference: order holds requester indices, most-preferred first.
  int order[$];
  int owner;
  int cur;

  logic [N-1:0] g_obs, rdy_obs;
  logic [W-1:0] d_obs;
  logic         v_obs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.i_valid = v;
    bus.i_last  = l;
    bus.i_data  = d;
    bus.i_ready = r;
  endtask

  task automatic model_reset();
    order.delete();
    for (int i = 0; i < N; i++) order.push_back(i);
    owner = -1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".grant"}, 64'(bus.o_grant), 64'(0));
    chk({tag, ".valid"}, 64'(bus.o_valid), 64'(0));
    chk({tag, ".last"},  64'(bus.o_last),  64'(0));
    chk({tag, ".data"},  64'(bus.o_data),  64'(0));
    chk({tag, ".ready"}, 64'(bus.o_ready), 64'(0));
  endtask

  // One clock: drive at negedge, check 1 ns later, advance model at posedge.
  task automatic cycle(input string tag);
    logic [N-1:0] eg, er;
    logic         ev, el;
    logic [W-1:0] ed;
    bit           found;
    drive();
    #1;
    cur = owner;
    if (cur < 0) begin
      for (int k = 0; k < order.size(); k++) begin
        if (cur < 0 && v[order[k]]) cur = order[k];
      end
    end
    eg = '0; er = '0; ev = 1'b0; el = 1'b0; ed = '0;
    if (cur >= 0) begin
      eg[cur] = 1'b1;
      er[cur] = r;
      ev      = v[cur];
      el      = l[cur];
      ed      = d[cur];
    end
    g_obs = bus.o_grant; rdy_obs = bus.o_ready; d_obs = bus.o_data; v_obs = bus.o_valid;
    chk({tag, ".grant"}, 64'(bus.o_grant), 64'(eg));
    chk({tag, ".valid"}, 64'(bus.o_valid), 64'(ev));
    chk({tag, ".last"},  64'(bus.o_last),  64'(el));
    chk({tag, ".data"},  64'(bus.o_data),  64'(ed));
    chk({tag, ".ready"}, 64'(bus.o_ready), 64'(er));
    @(posedge clk);
    if (cur >= 0) begin
      if (ev && r && el) begin
        found = 1'b0;
        for (int k = 0; k < order.size(); k++) begin
          if (!found && order[k] == cur) begin
            order.delete(k);
            found = 1'b1;
          end
        end
        order.push_back(cur);
        owner = -1;
      end else begin
        owner = cur;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset held with every requester valid: outputs must stay zero.
    v = '1; l = '1; d = '0; r = 1'b1;
    for (int i = 0; i < N; i++) d[i] = 32'h1000 + 32'(i);
    drive();
    model_reset();
    #2;
    chk_zero("in_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle: no requests for 10 cycles.
    v = '0; l = '0;
    for (int k = 0; k < 10; k++) begin
      cycle("idle");
      chk("idle.state", 64'(dut.state_q), 64'(TBCM_PACKET_MUX_IDLE));
    end

    // Concurrent single-beat traffic, rotating grants.
    v = '1; l = '1; r = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle("rr");
      chk("rr.seq", 64'(g_obs), 64'(seq[k]));
    end

    // 3-beat packet on req1 locks out req2.
    v = 4'b0110; l = 4'b0100; d[1] = 32'hA0; d[2] = 32'hB0;
    cycle("lock.a0");
    chk("lock.a0.data", 64'(d_obs), 64'h A0);
    chk("lock.a0.rdy2", 64'(rdy_obs[2]), 64'(0));
    d[1] = 32'hA1;
    cycle("lock.a1");
    chk("lock.a1.data", 64'(d_obs), 64'h A1);
    chk("lock.a1.rdy2", 64'(rdy_obs[2]), 64'(0));
    d[1] = 32'hA2; l = 4'b0110;
    cycle("lock.a2");
    chk("lock.a2.data", 64'(d_obs), 64'h A2);
    chk("lock.a2.rdy2", 64'(rdy_obs[2]), 64'(0));
    v = 4'b0100;
    cycle("lock.req2");
    chk("lock.req2.grant", 64'(g_obs), 64'(4'b0100));

    // Backpressure: req0 held 3 cycles while req3 waits.
    v = 4'b0001; l = 4'b1001; d[0] = 32'hC0; d[3] = 32'hD0; r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle("bp.hold");
      chk("bp.grant", 64'(g_obs), 64'(4'b0001));
      chk("bp.data", 64'(d_obs), 64'h C0);
      v = 4'b1001;
    end
    r = 1'b1;
    cycle("bp.done");
    chk("bp.done.grant", 64'(g_obs), 64'(4'b0001));
    v = 4'b1000;
    cycle("bp.req3");
    chk("bp.req3.grant", 64'(g_obs), 64'(4'b1000));

    // Mid-packet valid gap on req2 with competitors valid.
    v = 4'b0100; l = 4'b0000; d[2] = 32'hE0;
    cycle("gap.b0");
    v = 4'b0011; l = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      cycle("gap.hole");
      chk("gap.valid", 64'(v_obs), 64'(0));
      chk("gap.grant", 64'(g_obs), 64'(4'b0100));
    end
    v = 4'b0111; l = 4'b0111; d[2] = 32'hE1;
    cycle("gap.b1");
    chk("gap.b1.data", 64'(d_obs), 64'h E1);
    v = 4'b0011;
    cycle("gap.next");
    v = '0;
    cycle("gap.idle");

    // Reset during beat 2 of a 4-beat req3 packet.
    v = 4'b1000; l = 4'b0000; d[3] = 32'h30;
    cycle("mid.b0");
    d[3] = 32'h31;
    drive();
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("mid.rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    v = '1; l = '1;
    cycle("mid.after");
    chk("mid.after.grant", 64'(g_obs), 64'(4'b0001));

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      v = N'($urandom_range(0, 15));
      l = N'($urandom & $urandom);
      r = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) d[i] = $urandom;
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
